shift_16_left_rx: RTL
=====================

# shift_16_left_rx

Serial-to-parallel receiver for the 16-bit left-shift serial link. It reassembles the bit stream that the parallel-load shift register transmits MSB-first on its ShiftOut pin into a 16-bit word. The block sits at the far end of that link, framed by a Start marker and qualified by a per-bit Enable strobe. It holds each completed word in an output register with a Valid/Ack handshake and flags overrun and framing errors.

## Interface
- lpm_width, 16: word width; bit counter is $clog2(lpm_width) bits.
- lpm_direction, "LEFT": "LEFT" means the first received bit lands in Q[lpm_width-1] (MSB-first). "RIGHT" means the first received bit lands in Q[0].

Ports:
- Clock  in  1  sole clock; all logic on rising edge.
- Sclr  in  1  reset, synchronous, active-high.
- Enable  in  1  bit strobe; ShiftIn and Start are sampled only when Enable=1.
- ShiftIn  in  1  serial data bit.
- Start  in  1  frame marker; asserted together with Enable on the first bit of a word.
- Ack  in  1  consumer has taken Q; clears Valid.
- Q  out  lpm_width  last completed word (output holding register).
- Valid  out  1  Q holds an unacknowledged word.
- Busy  out  1  a frame is in progress.
- Overrun  out  1  sticky; a completed word was dropped because Valid was still set.
- FrameErr  out  1  one-cycle pulse; Start was seen mid-frame.

## Operation
- **States**
  - IDLE (Busy=0).
  - SHIFT (Busy=1, bit counter cnt = number of bits received so far, 1..lpm_width-1).
- **IDLE**
  - Enable=1 and Start=1: load the bit into the shift register, set cnt=1, go to SHIFT.
  - Any other combination, including Enable=1 with Start=0: ignored.
- **SHIFT, Enable=1, Start=0**
  - Shift the bit in (LEFT: sr = {sr[w-2:0], ShiftIn}; RIGHT: sr = {ShiftIn, sr[w-1:1]}) and increment cnt.
  - If this is bit lpm_width (cnt was lpm_width-1), the word is complete: go to IDLE and run the completion rules below.
- **SHIFT, Enable=1, Start=1** (restart)
  - Abort the current frame and pulse FrameErr.
  - Treat the bit as bit 1 of a new frame: cnt=1, stay in SHIFT.
  - This also applies when cnt=lpm_width-1; that partial word is discarded.
- **SHIFT, Enable=0:** hold all state; there is no timeout.
- **Completion rules** (evaluated with the Ack value sampled on the same edge)
  - Valid=0, or Ack=1: Q <= completed word, Valid <= 1.
  - Valid=1 and Ack=0: Q and Valid are unchanged, the new word is discarded, Overrun <= 1.
- **Ack without a completion:** Ack=1 clears Valid. Ack while Valid=0 has no effect.
- **Overrun** stays set until Sclr.
- **Sclr** (any state, overrides all other inputs): state=IDLE, cnt=0, shift register=0, Q=0, Valid=0, Busy=0, Overrun=0, FrameErr=0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: the edge that samples the last bit also updates Q/Valid, so the word is visible in the cycle after that edge. No additional pipeline stage.
- Minimum frame is lpm_width consecutive Enable cycles. A back-to-back Start is legal on the cycle immediately after the last bit, because the block is already in IDLE.
- Busy rises after the edge that samples Start and falls after the edge that samples the last bit.
- FrameErr is high for exactly the one cycle after the edge that samples the offending Start.
- Valid is held indefinitely until Ack. Ack is level-sampled on each edge and needs no pulse-width requirement.

## Structure
- Shared package `shift16_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - direction constants DIR_LEFT and DIR_RIGHT;
  - the default width constant (16).
- One natural sub-module, `shift16_rx_core`: shift register plus bit counter, with Enable, Start and Sclr inputs and done/word outputs. The top level adds the holding register, handshake and error flags.

## Test plan
- Sclr, then Start+Enable with 16 consecutive bits of 0xA5C3 MSB-first -> one cycle after the 16th edge: Q=0xA5C3, Valid=1, Busy=0, FrameErr=0.
- Same word with Enable low for 3 cycles between bits 4/5 and 11/12 -> Q=0xA5C3 only after the 16th enabled bit; Busy=1 throughout the gaps.
- Frame aborted by Start on bit 9, followed by 16 bits of 0x1234 -> FrameErr pulse of one cycle, then Q=0x1234, Valid=1, Overrun=0.
- Frames 0xFFFF then 0x0F0F back to back with Ack=0 -> Q=0xFFFF, Valid=1, Overrun=1. Repeat with Ack=1 on the second frame's completion edge -> Q=0x0F0F, Valid=1, Overrun=0.
- Sclr asserted after 7 bits of a frame -> all outputs 0 on the next cycle; a following frame of 0x8001 is received correctly.
- lpm_direction="RIGHT", bit stream 1,0,0,…,0 -> Q=0x0001.

Source files
------------

// File: rtl/shift16_pkg.sv
// Shared definitions for the 16-bit left-shift serial link receiver:
// receiver state encoding, bit-order selectors and the default word width.
package shift16_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/shift16_rx_core.sv
// Receive datapath: shift register plus bit counter for one frame.
// Ports:
//   clk       rising-edge clock
//   sclr      synchronous active-high clear
//   enable    bit strobe; shift_in/start are sampled only when high
//   shift_in  serial data bit
//   start     frame marker, accompanies the first bit of a word
//   done      combinational: the current edge samples the last bit of a word
//   abort     combinational: the current edge samples a Start mid-frame
//   word      combinational: the completed word (valid while done=1)
//   busy      registered: a frame is in progress
module shift16_rx_core
  import shift16_pkg::*;
#(
  parameter int unsigned lpm_width     = DEFAULT_WIDTH,
  parameter string       lpm_direction = DIR_LEFT
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 enable,
  input  logic                 shift_in,
  input  logic                 start,
  output logic                 done,
  output logic                 abort,
  output logic [lpm_width-1:0] word,
  output logic                 busy
);

  localparam int unsigned CNT_W    = $clog2(lpm_width);
  localparam bit          IS_RIGHT = (lpm_direction == DIR_RIGHT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(lpm_width - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [lpm_width-1:0] sr;
  logic [lpm_width-1:0] shifted;
  logic [lpm_width-1:0] first_bit;

  always_comb begin
    shifted   = IS_RIGHT ? {shift_in, sr[lpm_width-1:1]} : {sr[lpm_width-2:0], shift_in};
    first_bit = IS_RIGHT ? {shift_in, {(lpm_width-1){1'b0}}}
                         : {{(lpm_width-1){1'b0}}, shift_in};
  end

  // Completion is decoded from the current count so the top level can
  // capture the word on the same edge that samples the last bit.
  assign done  = (state == SHIFT) && enable && !start && (cnt == LAST_CNT);
  assign abort = (state == SHIFT) && enable && start;
  assign word  = shifted;
  assign busy  = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= first_bit;
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            sr  <= first_bit;
            cnt <= CNT_W'(1);
          end else if (cnt == LAST_CNT) begin
            sr    <= shifted;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            sr  <= shifted;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shift_16_left_rx.sv
// Serial-to-parallel receiver for the 16-bit left-shift serial link.
// Reassembles Start-framed, Enable-qualified serial bits into a word held
// in an output register with a Valid/Ack handshake.
// Ports:
//   Clock     rising-edge clock
//   Sclr      synchronous active-high reset
//   Enable    bit strobe
//   ShiftIn   serial data bit
//   Start     frame marker on the first bit of a word
//   Ack       consumer has taken Q; clears Valid
//   Q         last completed word
//   Valid     Q holds an unacknowledged word
//   Busy      frame in progress
//   Overrun   sticky: a completed word was dropped while Valid was set
//   FrameErr  one-cycle pulse: Start seen mid-frame
module shift_16_left_rx
  import shift16_pkg::*;
#(
  parameter int unsigned lpm_width     = DEFAULT_WIDTH,
  parameter string       lpm_direction = DIR_LEFT
) (
  input  logic                 Clock,
  input  logic                 Sclr,
  input  logic                 Enable,
  input  logic                 ShiftIn,
  input  logic                 Start,
  input  logic                 Ack,
  output logic [lpm_width-1:0] Q,
  output logic                 Valid,
  output logic                 Busy,
  output logic                 Overrun,
  output logic                 FrameErr
);

  logic                 done;
  logic                 abort;
  logic [lpm_width-1:0] word;

  shift16_rx_core #(
    .lpm_width     (lpm_width),
    .lpm_direction (lpm_direction)
  ) u_core (
    .clk      (Clock),
    .sclr     (Sclr),
    .enable   (Enable),
    .shift_in (ShiftIn),
    .start    (Start),
    .done     (done),
    .abort    (abort),
    .word     (word),
    .busy     (Busy)
  );

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      Q        <= '0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      FrameErr <= abort;
      if (done) begin
        // Ack on the completion edge frees the holding register for the new word.
        if (!Valid || Ack) begin
          Q     <= word;
          Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Ack) begin
        Valid <= 1'b0;
      end
    end
  end

endmodule
